cache_refill_ctrl: RTL
======================

Name: cache_refill_ctrl

Overview:
Line-refill sequencer for the cache miss path. On a miss it issues LINE_WORDS single-word reads through the control interface of the AHB-out read controller (sel/addr/rdata/ready), writes each returned word into the data RAM and forwards the critical word to the CPU. Addressing is critical-word-first with wrap. Sits between the cache miss/tag logic and the AHB-out controller.

Parameters:
LINE_WORDS, 4, words per cache line; power of 2, >= 2
WRAP, 1, 1 = critical-word-first wrapping order; 0 = linear order from line base

Ports:
i_hclk  in  1  clock
i_hnreset  in  1  async active-low reset
i_miss_req  in  1  refill request; held by requester until acked
i_miss_addr  in  30  word address of the missing word
o_miss_ack  out  1  request accepted (1-cycle pulse)
o_busy  out  1  refill in progress (FILL or DONE)
o_crit_valid  out  1  critical word valid (1-cycle pulse)
o_crit_data  out  32  critical word
o_done  out  1  line complete (1-cycle pulse)
o_sel  out  1  to AHB-out controller: issue read
o_addr  out  30  to AHB-out controller: word address
i_rdata  in  32  from AHB-out controller: read data
i_ready  in  1  from AHB-out controller: ready / transfer advance
o_wr_en  out  1  data RAM write enable
o_wr_addr  out  30  data RAM word address
o_wr_data  out  32  data RAM write data

Behaviour:
- One clock (i_hclk); reset asynchronous, active-low (i_hnreset). Reset: state IDLE, counters 0, latched address 0, every output 0.
- OW = log2(LINE_WORDS). Latched line base = miss_addr[29:OW], start offset s = miss_addr[OW-1:0].
- n-th issued word offset: WRAP=1 -> (s+n) mod LINE_WORDS (natural OW-bit wrap); WRAP=0 -> n. o_addr = {base, offset}.
- States: IDLE, FILL, DONE.
- IDLE: o_miss_ack = i_miss_req (combinational); on ack latch address, clear issue_cnt/recv_cnt (OW+1 bits each) -> FILL.
- FILL, issue: o_sel = (issue_cnt < LINE_WORDS). Address accepted when o_sel & i_ready; issue_cnt++. While i_ready=0, o_sel/o_addr held stable.
- FILL, receive: an accepted address's data is valid on i_rdata at the next cycle with i_ready=1. In that cycle o_wr_en=1, o_wr_addr = that word's address, o_wr_data = i_rdata, recv_cnt++. Issue of word n+1 and receipt of word n occur in the same cycle (pipelined). At most one word outstanding; recv never exceeds issue.
- Critical word: o_crit_valid pulses with o_crit_data = i_rdata on receipt of the word whose offset == s (n=0 when WRAP=1). Exactly one pulse per refill.
- When recv_cnt reaches LINE_WORDS (last write cycle) -> DONE. DONE: o_done=1 for one cycle, o_sel=0 -> IDLE.
- o_busy = state != IDLE. o_sel, o_wr_en, o_crit_valid are 0 outside FILL. o_addr = 0 in IDLE.
- Requests only accepted in IDLE; i_miss_req during FILL/DONE ignored, no ack. Back-to-back: next ack earliest the cycle after o_done.
- Latency (i_ready=1 always, LINE_WORDS=4): ack cycle 0; o_sel cycles 1-4; writes cycles 2-5; crit cycle 2; o_done cycle 6; new ack possible cycle 7.
- Reset mid-fill: immediate return to IDLE, no o_done, no further writes; partial line left to tag logic (valid bit not set).
- i_rdata is only sampled when a word is outstanding and i_ready=1; otherwise ignored.

Test Plan:
- Reset then idle: i_hnreset low/high, no req -> all outputs 0, o_busy 0 for 10 cycles.
- WRAP=1, miss_addr=0x0000_0012, i_ready=1, rdata=addr*4 -> o_addr 0x12,0x13,0x10,0x11 cycles 1-4; writes same order cycles 2-5 with data 0x48,0x4C,0x40,0x44; crit_valid cycle 2 data 0x48; o_done cycle 6.
- WRAP=0, miss_addr=0x22 -> o_addr 0x20..0x23; crit_valid on write of 0x22 (cycle 4); single pulse.
- Wait states: i_ready low 2 cycles after first address accepted -> o_sel/o_addr held at 0x13, no write until i_ready=1; total 4 writes, o_done cycle 8.
- i_miss_req held high through refill -> single ack at cycle 0, next ack cycle 7 with new address latched.
- Reset asserted cycle 3 of fill -> all outputs 0 same cycle, IDLE after release, no o_done; fresh refill completes normally.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// cache_refill_ctrl_if: miss-request, AHB-out read and data-RAM write signals of the refill sequencer
//   master: the refill sequencer (drives acks, read requests, RAM writes)
//   slave : miss/tag logic, AHB-out controller and data RAM seen as one environment
interface cache_refill_ctrl_if;
    logic        i_miss_req;
    logic [29:0] i_miss_addr;
    logic        o_miss_ack;
    logic        o_busy;
    logic        o_crit_valid;
    logic [31:0] o_crit_data;
    logic        o_done;
    logic        o_sel;
    logic [29:0] o_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        o_wr_en;
    logic [29:0] o_wr_addr;
    logic [31:0] o_wr_data;
    modport master (
        input  i_miss_req, i_miss_addr, i_rdata, i_ready,
        output o_miss_ack, o_busy, o_crit_valid, o_crit_data, o_done,
               o_sel, o_addr, o_wr_en, o_wr_addr, o_wr_data
    );
    modport slave (
        output i_miss_req, i_miss_addr, i_rdata, i_ready,
        input  o_miss_ack, o_busy, o_crit_valid, o_crit_data, o_done,
               o_sel, o_addr, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: cache line refill sequencer, critical-word-first reads into the data RAM
//   i_hclk, i_hnreset : clock, async active-low reset
//   bus.i_miss_req/i_miss_addr -> o_miss_ack, o_busy, o_done : miss request handshake
//   bus.o_sel/o_addr <- i_rdata/i_ready                       : AHB-out read controller
//   bus.o_wr_en/o_wr_addr/o_wr_data                           : data RAM write port
//   bus.o_crit_valid/o_crit_data                              : critical word to the CPU
module cache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter bit WRAP       = 1'b1
) (
    input logic                i_hclk,
    input logic                i_hnreset,
    cache_refill_ctrl_if.master bus
);
    localparam int OW = $clog2(LINE_WORDS);
    localparam logic [OW:0] LW   = (OW+1)'(LINE_WORDS);
    localparam logic [OW:0] LAST = (OW+1)'(LINE_WORDS - 1);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    state_t          state, state_d;
    logic [29-OW:0]  base, base_d;
    logic [OW-1:0]   s, s_d;
    logic [OW:0]     issue_cnt, issue_d, recv_cnt, recv_d;
    logic [OW-1:0]   issue_off, recv_off;
    logic            rx;
    assign issue_off = WRAP ? s + issue_cnt[OW-1:0] : issue_cnt[OW-1:0];
    assign recv_off  = WRAP ? s + recv_cnt[OW-1:0]  : recv_cnt[OW-1:0];
    always_ff @(posedge i_hclk or negedge i_hnreset) begin
        if (!i_hnreset) begin
            state     <= IDLE;
            base      <= '0;
            s         <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state     <= state_d;
            base      <= base_d;
            s         <= s_d;
            issue_cnt <= issue_d;
            recv_cnt  <= recv_d;
        end
    end
    always_comb begin
        state_d          = state;
        base_d           = base;
        s_d              = s;
        issue_d          = issue_cnt;
        recv_d           = recv_cnt;
        rx               = 1'b0;
        bus.o_miss_ack   = 1'b0;
        bus.o_busy       = state != IDLE;
        bus.o_crit_valid = 1'b0;
        bus.o_crit_data  = '0;
        bus.o_done       = 1'b0;
        bus.o_sel        = 1'b0;
        bus.o_addr       = '0;
        bus.o_wr_en      = 1'b0;
        bus.o_wr_addr    = '0;
        bus.o_wr_data    = '0;
        case (state)
            IDLE: begin
                // ack is gated by reset so every output reads 0 while reset is held
                bus.o_miss_ack = bus.i_miss_req & i_hnreset;
                if (bus.o_miss_ack) begin
                    state_d = FILL;
                    base_d  = bus.i_miss_addr[29:OW];
                    s_d     = bus.i_miss_addr[OW-1:0];
                    issue_d = '0;
                    recv_d  = '0;
                end
            end
            FILL: begin
                // one word outstanding at most, so issued != received means data is due
                rx               = (issue_cnt != recv_cnt) && bus.i_ready;
                bus.o_sel        = issue_cnt < LW;
                bus.o_addr       = bus.o_sel ? {base, issue_off} : '0;
                bus.o_wr_en      = rx;
                bus.o_wr_addr    = rx ? {base, recv_off} : '0;
                bus.o_wr_data    = rx ? bus.i_rdata : '0;
                bus.o_crit_valid = rx && (recv_off == s);
                bus.o_crit_data  = bus.o_crit_valid ? bus.i_rdata : '0;
                issue_d          = (bus.o_sel && bus.i_ready) ? issue_cnt + 1'b1 : issue_cnt;
                recv_d           = rx ? recv_cnt + 1'b1 : recv_cnt;
                state_d          = (rx && recv_cnt == LAST) ? DONE : FILL;
            end
            DONE: begin
                bus.o_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
